// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake bundle between the instruction source and the
// ALU sequencer.
interface alu_seq_ctrl_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [1:0] instr_rd;
   logic [1:0] instr_ra;
   logic [1:0] instr_rb;
   logic       instr_imm_en;
   logic [3:0] instr_imm;

   modport master (
      output instr_valid,
      input  instr_ready,
      output instr_op,
      output instr_rd,
      output instr_ra,
      output instr_rb,
      output instr_imm_en,
      output instr_imm
   );

   modport slave (
      input  instr_valid,
      output instr_ready,
      input  instr_op,
      input  instr_rd,
      input  instr_ra,
      input  instr_rb,
      input  instr_imm_en,
      input  instr_imm
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ALU instruction sequencer: accepts one instruction at a time, drives the
// 4-bit ALU from a local 4x4 register file, holds the operands for ALU_WAIT
// cycles, then writes the result and flag back.
module alu_seq_ctrl #(
   parameter int unsigned ALU_WAIT = 1,
   parameter int unsigned NREGS    = 4
) (
   input  logic               clk,
   input  logic               rst,
   alu_seq_ctrl_if.slave      instr,
   output logic [3:0]         alu_a,
   output logic [3:0]         alu_b,
   output logic [3:0]         alu_control,
   output logic               alu_flag_in,
   input  logic [3:0]         alu_result,
   input  logic               alu_flags,
   output logic               done,
   output logic               err,
   output logic [3:0]         result_out,
   output logic               flag_q,
   input  logic [1:0]         dbg_sel,
   output logic [3:0]         dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   localparam logic [3:0] OP_LOAD    = 4'hF;
   localparam logic [3:0] OP_ALU_MAX = 4'h9;
   localparam logic [3:0] WAIT_INIT  = 4'(ALU_WAIT - 1);

   state_t     r_state;
   logic       r_ready;
   logic       r_done;
   logic       r_err;
   logic [3:0] r_alu_a;
   logic [3:0] r_alu_b;
   logic [3:0] r_alu_ctrl;
   logic       r_flag;
   logic [3:0] r_result;
   logic [3:0] r_wait;
   logic [1:0] r_rd;
   logic [3:0] r_regs [NREGS];

   logic       w_accept;

   assign w_accept = instr.instr_valid && r_ready;

   // Sequencer FSM with register file, flag and all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_ctrl <= '0;
         r_flag     <= 1'b0;
         r_result   <= '0;
         r_wait     <= '0;
         r_rd       <= '0;
         for (int unsigned i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rd    <= instr.instr_rd;
                  r_ready <= 1'b0;
                  if (instr.instr_op <= OP_ALU_MAX) begin
                     // Operands are snapshotted here so rd aliasing ra/rb
                     // cannot disturb them before write-back.
                     r_alu_a    <= r_regs[instr.instr_ra];
                     r_alu_b    <= instr.instr_imm_en ? instr.instr_imm
                                                      : r_regs[instr.instr_rb];
                     r_alu_ctrl <= instr.instr_op;
                     r_wait     <= WAIT_INIT;
                     r_state    <= S_EXEC;
                  end else if (instr.instr_op == OP_LOAD) begin
                     r_regs[instr.instr_rd] <= instr.instr_imm;
                     r_result               <= instr.instr_imm;
                     r_done                 <= 1'b1;
                     r_state                <= S_DONE;
                  end else begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_EXEC: begin
               if (r_wait == 4'd0) begin
                  r_regs[r_rd] <= alu_result;
                  r_result     <= alu_result;
                  r_flag       <= alu_flags;
                  r_alu_a      <= '0;
                  r_alu_b      <= '0;
                  r_alu_ctrl   <= '0;
                  r_done       <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end

            default: begin
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign instr.instr_ready = r_ready;
   assign alu_a             = r_alu_a;
   assign alu_b             = r_alu_b;
   assign alu_control       = r_alu_ctrl;
   assign alu_flag_in       = r_flag;
   assign done              = r_done;
   assign err               = r_err;
   assign result_out        = r_result;
   assign flag_q            = r_flag;
   assign dbg_data          = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance with ALU_WAIT=1 and one with
// ALU_WAIT=3, both fed by a stub ALU whose result/flag the bench sets.
module tb_alu_seq_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] stub_res;
   logic       stub_flg;

   alu_seq_ctrl_if ifa ();
   alu_seq_ctrl_if ifb ();

   logic [3:0] a_alu_a, a_alu_b, a_alu_ctrl, a_result, a_dbg;
   logic       a_flag_in, a_done, a_err, a_flag;
   logic [1:0] a_dbg_sel;

   logic [3:0] b_alu_a, b_alu_b, b_alu_ctrl, b_result, b_dbg;
   logic       b_flag_in, b_done, b_err, b_flag;
   logic [1:0] b_dbg_sel;

   int n_pass;
   int n_total;

   alu_seq_ctrl #(.ALU_WAIT(1), .NREGS(4)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .instr       (ifa),
      .alu_a       (a_alu_a),
      .alu_b       (a_alu_b),
      .alu_control (a_alu_ctrl),
      .alu_flag_in (a_flag_in),
      .alu_result  (stub_res),
      .alu_flags   (stub_flg),
      .done        (a_done),
      .err         (a_err),
      .result_out  (a_result),
      .flag_q      (a_flag),
      .dbg_sel     (a_dbg_sel),
      .dbg_data    (a_dbg)
   );

   alu_seq_ctrl #(.ALU_WAIT(3), .NREGS(4)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .instr       (ifb),
      .alu_a       (b_alu_a),
      .alu_b       (b_alu_b),
      .alu_control (b_alu_ctrl),
      .alu_flag_in (b_flag_in),
      .alu_result  (stub_res),
      .alu_flags   (stub_flg),
      .done        (b_done),
      .err         (b_err),
      .result_out  (b_result),
      .flag_q      (b_flag),
      .dbg_sel     (b_dbg_sel),
      .dbg_data    (b_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drv_a(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic ie, input logic [3:0] imm);
      ifa.instr_op     = op;
      ifa.instr_rd     = rd;
      ifa.instr_ra     = ra;
      ifa.instr_rb     = rb;
      ifa.instr_imm_en = ie;
      ifa.instr_imm    = imm;
   endtask

   task automatic drv_b(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic ie, input logic [3:0] imm);
      ifb.instr_op     = op;
      ifb.instr_rd     = rd;
      ifb.instr_ra     = ra;
      ifb.instr_rb     = rb;
      ifb.instr_imm_en = ie;
      ifb.instr_imm    = imm;
   endtask

   // Load immediate on instance A: done one cycle after accept, then idle.
   task automatic load_a(input logic [1:0] rd, input logic [3:0] imm);
      drv_a(4'hF, rd, 2'd0, 2'd0, 1'b0, imm);
      ifa.instr_valid = 1'b1;
      tick();
      ifa.instr_valid = 1'b0;
      chk("load_done", {7'd0, a_done}, 8'h01);
      chk("load_err", {7'd0, a_err}, 8'h00);
      chk("load_ready", {7'd0, ifa.instr_ready}, 8'h00);
      chk("load_result", {4'd0, a_result}, {4'd0, imm});
      chk("load_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h00);
      tick();
      chk("load_done_clr", {7'd0, a_done}, 8'h00);
      chk("load_ready_back", {7'd0, ifa.instr_ready}, 8'h01);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1;
      stub_res = 4'h0;
      stub_flg = 1'b0;
      a_dbg_sel = 2'd0;
      b_dbg_sel = 2'd0;
      ifa.instr_valid = 1'b0;
      ifb.instr_valid = 1'b0;
      drv_a(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0);
      drv_b(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_ready", {7'd0, ifa.instr_ready}, 8'h01);
      chk("rst_done", {7'd0, a_done}, 8'h00);
      chk("rst_err", {7'd0, a_err}, 8'h00);
      chk("rst_result", {4'd0, a_result}, 8'h00);
      chk("rst_flag", {7'd0, a_flag}, 8'h00);
      chk("rst_alu_a", {4'd0, a_alu_a}, 8'h00);
      chk("rst_alu_b", {4'd0, a_alu_b}, 8'h00);
      chk("rst_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h00);
      for (int i = 0; i < 4; i++) begin
         a_dbg_sel = 2'(i);
         #1;
         chk("rst_reg", {4'd0, a_dbg}, 8'h00);
      end

      // Loads and register-file readback
      load_a(2'd1, 4'hB);
      load_a(2'd2, 4'h7);
      a_dbg_sel = 2'd1;
      #1;
      chk("dbg_r1", {4'd0, a_dbg}, 8'h0B);
      a_dbg_sel = 2'd2;
      #1;
      chk("dbg_r2", {4'd0, a_dbg}, 8'h07);

      // ALU op 3: R3 <= f(R1, R2), stub returns 5 / flag 1
      stub_res = 4'h5;
      stub_flg = 1'b1;
      drv_a(4'h3, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0);
      ifa.instr_valid = 1'b1;
      tick();
      ifa.instr_valid = 1'b0;
      chk("exec_ready", {7'd0, ifa.instr_ready}, 8'h00);
      chk("exec_done", {7'd0, a_done}, 8'h00);
      chk("exec_alu_a", {4'd0, a_alu_a}, 8'h0B);
      chk("exec_alu_b", {4'd0, a_alu_b}, 8'h07);
      chk("exec_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h03);
      chk("exec_flag_in", {7'd0, a_flag_in}, 8'h00);
      tick();
      chk("alu_done", {7'd0, a_done}, 8'h01);
      chk("alu_err", {7'd0, a_err}, 8'h00);
      chk("alu_ready_done", {7'd0, ifa.instr_ready}, 8'h00);
      chk("alu_result", {4'd0, a_result}, 8'h05);
      chk("alu_flag", {7'd0, a_flag}, 8'h01);
      a_dbg_sel = 2'd3;
      #1;
      chk("alu_r3", {4'd0, a_dbg}, 8'h05);
      tick();
      chk("alu_idle_ready", {7'd0, ifa.instr_ready}, 8'h01);
      chk("alu_idle_done", {7'd0, a_done}, 8'h00);
      chk("alu_flag_in_next", {7'd0, a_flag_in}, 8'h01);

      // Illegal opcode 0xC
      drv_a(4'hC, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0);
      ifa.instr_valid = 1'b1;
      tick();
      ifa.instr_valid = 1'b0;
      chk("ill_done", {7'd0, a_done}, 8'h01);
      chk("ill_err", {7'd0, a_err}, 8'h01);
      chk("ill_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h00);
      chk("ill_alu_a", {4'd0, a_alu_a}, 8'h00);
      chk("ill_result", {4'd0, a_result}, 8'h05);
      chk("ill_flag", {7'd0, a_flag}, 8'h01);
      a_dbg_sel = 2'd0;
      #1;
      chk("ill_r0", {4'd0, a_dbg}, 8'h00);
      tick();
      chk("ill_done_clr", {7'd0, a_done}, 8'h00);
      chk("ill_err_clr", {7'd0, a_err}, 8'h00);

      // Load leaves flag untouched
      load_a(2'd0, 4'h3);
      chk("load_keeps_flag", {7'd0, a_flag}, 8'h01);

      // Back-to-back ALU ops with instr_valid held high
      stub_res = 4'h9;
      stub_flg = 1'b0;
      drv_a(4'h3, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0);
      ifa.instr_valid = 1'b1;
      tick();
      chk("bp1_ready_exec", {7'd0, ifa.instr_ready}, 8'h00);
      chk("bp1_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h03);
      drv_a(4'h1, 2'd2, 2'd3, 2'd0, 1'b1, 4'h6);
      tick();
      chk("bp1_done", {7'd0, a_done}, 8'h01);
      chk("bp1_ready_done", {7'd0, ifa.instr_ready}, 8'h00);
      chk("bp1_result", {4'd0, a_result}, 8'h09);
      chk("bp1_flag", {7'd0, a_flag}, 8'h00);
      stub_res = 4'hA;
      stub_flg = 1'b1;
      tick();
      chk("bp_idle_ready", {7'd0, ifa.instr_ready}, 8'h01);
      chk("bp_idle_done", {7'd0, a_done}, 8'h00);
      chk("bp_idle_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h00);
      tick();
      ifa.instr_valid = 1'b0;
      chk("bp2_ready_exec", {7'd0, ifa.instr_ready}, 8'h00);
      chk("bp2_alu_a", {4'd0, a_alu_a}, 8'h05);
      chk("bp2_alu_b", {4'd0, a_alu_b}, 8'h06);
      chk("bp2_alu_ctrl", {4'd0, a_alu_ctrl}, 8'h01);
      chk("bp2_flag_in", {7'd0, a_flag_in}, 8'h00);
      tick();
      chk("bp2_done", {7'd0, a_done}, 8'h01);
      chk("bp2_result", {4'd0, a_result}, 8'h0A);
      chk("bp2_flag", {7'd0, a_flag}, 8'h01);
      a_dbg_sel = 2'd2;
      #1;
      chk("bp2_r2", {4'd0, a_dbg}, 8'h0A);
      a_dbg_sel = 2'd0;
      #1;
      chk("bp1_r0", {4'd0, a_dbg}, 8'h09);
      tick();

      // Instance B, ALU_WAIT=3: immediate operand with rd == ra
      drv_b(4'hF, 2'd1, 2'd0, 2'd0, 1'b0, 4'hB);
      ifb.instr_valid = 1'b1;
      tick();
      ifb.instr_valid = 1'b0;
      chk("b_load_done", {7'd0, b_done}, 8'h01);
      tick();
      stub_res = 4'hE;
      stub_flg = 1'b1;
      drv_b(4'h0, 2'd1, 2'd1, 2'd3, 1'b1, 4'h2);
      ifb.instr_valid = 1'b1;
      tick();
      ifb.instr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("b_hold_alu_a", {4'd0, b_alu_a}, 8'h0B);
         chk("b_hold_alu_b", {4'd0, b_alu_b}, 8'h02);
         chk("b_hold_done", {7'd0, b_done}, 8'h00);
         chk("b_hold_ready", {7'd0, ifb.instr_ready}, 8'h00);
         tick();
      end
      chk("b_done", {7'd0, b_done}, 8'h01);
      chk("b_err", {7'd0, b_err}, 8'h00);
      chk("b_result", {4'd0, b_result}, 8'h0E);
      chk("b_flag", {7'd0, b_flag}, 8'h01);
      b_dbg_sel = 2'd1;
      #1;
      chk("b_r1", {4'd0, b_dbg}, 8'h0E);
      tick();
      chk("b_idle_ready", {7'd0, ifb.instr_ready}, 8'h01);

      // Reset for two cycles while instance A is in EXEC
      stub_res = 4'h7;
      stub_flg = 1'b0;
      drv_a(4'h3, 2'd1, 2'd1, 2'd2, 1'b0, 4'h0);
      ifa.instr_valid = 1'b1;
      tick();
      ifa.instr_valid = 1'b0;
      chk("mid_exec_ready", {7'd0, ifa.instr_ready}, 8'h00);
      rst = 1'b1;
      tick();
      chk("mid_rst_done", {7'd0, a_done}, 8'h00);
      chk("mid_rst_result", {4'd0, a_result}, 8'h00);
      chk("mid_rst_flag", {7'd0, a_flag}, 8'h00);
      chk("mid_rst_alu_a", {4'd0, a_alu_a}, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {7'd0, ifa.instr_ready}, 8'h01);
      chk("post_rst_done", {7'd0, a_done}, 8'h00);
      chk("post_rst_flag_in", {7'd0, a_flag_in}, 8'h00);
      for (int i = 0; i < 4; i++) begin
         a_dbg_sel = 2'(i);
         #1;
         chk("post_rst_reg", {4'd0, a_dbg}, 8'h00);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
